// File: rtl/voltage_stats_pkg.sv
// Shared types and constants for the voltage statistics reader.
//   DATA_W       - display sample width (12-bit ADC units)
//   ACC_W        - accumulator word width from the upstream statistics block
//   MAX_LOG2_WIN - largest window exponent whose energy still fits in ACC_W
//   vs_state_e   - reader FSM states
//   pp_calc      - saturating peak-to-peak helper
package voltage_stats_pkg;

  localparam int unsigned DATA_W       = 12;
  localparam int unsigned ACC_W        = 32;
  localparam int unsigned MAX_LOG2_WIN = 8;
  localparam int unsigned RAD_W        = 2 * DATA_W;
  localparam int unsigned PEAK_MAX     = (1 << DATA_W) - 1;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StSqrt,
    StDone
  } vs_state_e;

  // Max minus min, zero when the window extremes are inverted, clipped to DATA_W.
  function automatic logic [DATA_W-1:0] pp_calc(input logic [ACC_W-1:0] max_v,
                                                input logic [ACC_W-1:0] min_v);
    logic [ACC_W-1:0] diff;
    diff = max_v - min_v;
    if (max_v < min_v) begin
      pp_calc = '0;
    end else if (diff > ACC_W'(PEAK_MAX)) begin
      pp_calc = '1;
    end else begin
      pp_calc = diff[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Restoring bit-serial integer square root, one root bit per cycle.
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   start_i       - load radicand_i and begin (one cycle)
//   radicand_i    - RAD_W-bit unsigned radicand
//   done_o        - high in the cycle the final root bit is resolved
//   root_o        - floor(sqrt(radicand)); valid while done_o is high
module isqrt_seq
  import voltage_stats_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [RAD_W-1:0]  radicand_i,
  output logic              done_o,
  output logic [DATA_W-1:0] root_o
);

  localparam int unsigned REM_W = DATA_W + 2;
  localparam logic [3:0]  LAST_STEP = 4'(DATA_W - 1);

  logic [RAD_W-1:0]  rad_q, rad_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] root_q, root_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              active_q, active_d;

  logic [REM_W+1:0]  rem_sh;
  logic [REM_W+1:0]  trial;

  always_comb begin
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    // Bring down the next radicand bit pair and try (4*root + 1).
    rem_sh   = {rem_q, rad_q[RAD_W-1 -: 2]};
    trial    = {2'b00, root_q, 2'b01};
    if (start_i) begin
      rad_d    = radicand_i;
      rem_d    = '0;
      root_d   = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      rad_d = rad_q << 2;
      if (rem_sh >= trial) begin
        rem_d  = REM_W'(rem_sh - trial);
        root_d = {root_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d  = REM_W'(rem_sh);
        root_d = {root_q[DATA_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == LAST_STEP) begin
        active_d = 1'b0;
      end
    end
  end

  assign done_o = active_q && (cnt_q == LAST_STEP);
  assign root_o = root_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/voltage_stats_reader.sv
// Voltage statistics reader: issues the MEAN_FLAG window strobe to the
// accumulator, captures its latched sum / sum-of-squares / max / min and
// produces display-ready mean, RMS and peak-to-peak values.
//   CLK, RST      - clock, asynchronous active-high reset
//   EN            - window generation enable
//   MEAN_FLAG     - one-cycle window strobe (period 2^LOG2_WIN + 1 cycles)
//   SUM_IN, SUM2_IN, MAX_IN, MIN_IN - accumulator results
//   MEAN_OUT, RMS_OUT, PP_OUT       - registered results
//   RESULT_VALID  - one-cycle pulse when results update
//   BUSY          - high from capture through result
// Build option: define VOLTAGE_RMS_EN to compile in the RMS square-root path;
// otherwise RMS_OUT is 0 and results follow capture by one cycle.
// LOG2_WIN must be within 1..MAX_LOG2_WIN.
module voltage_stats_reader
  import voltage_stats_pkg::*;
#(
  parameter int unsigned LOG2_WIN = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  output logic              MEAN_FLAG,
  input  logic [ACC_W-1:0]  SUM_IN,
  input  logic [ACC_W-1:0]  SUM2_IN,
  input  logic [ACC_W-1:0]  MAX_IN,
  input  logic [ACC_W-1:0]  MIN_IN,
  output logic [DATA_W-1:0] MEAN_OUT,
  output logic [DATA_W-1:0] RMS_OUT,
  output logic [DATA_W-1:0] PP_OUT,
  output logic              RESULT_VALID,
  output logic              BUSY
);

  localparam int unsigned     CNT_W    = LOG2_WIN + 1;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(1 << LOG2_WIN);
  localparam logic [CNT_W-1:0] WIN_PRE  = CNT_W'((1 << LOG2_WIN) - 1);

  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              mean_flag_q, mean_flag_d;
  vs_state_e         state_q, state_d;
  logic              primed_q, primed_d;
  logic [DATA_W-1:0] mean_out_q, mean_out_d;
  logic [DATA_W-1:0] pp_out_q, pp_out_d;
  logic              rv_q, rv_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mean_cap;
  logic [DATA_W-1:0] pp_cap;

  assign mean_cap = DATA_W'(SUM_IN >> LOG2_WIN);
  assign pp_cap   = pp_calc(MAX_IN, MIN_IN);

`ifdef VOLTAGE_RMS_EN
  logic [ACC_W-1:0]  prev_sum2_q, prev_sum2_d;
  logic [DATA_W-1:0] rms_out_q, rms_out_d;
  logic [DATA_W-1:0] mean_pend_q, mean_pend_d;
  logic [DATA_W-1:0] pp_pend_q, pp_pend_d;
  logic [ACC_W-1:0]  energy;
  logic [RAD_W-1:0]  radicand;
  logic              sqrt_start;
  logic              sqrt_done;
  logic [DATA_W-1:0] sqrt_root;

  // Sum of squares is cumulative upstream; modular subtraction handles wrap.
  assign energy   = SUM2_IN - prev_sum2_q;
  assign radicand = RAD_W'(energy >> LOG2_WIN);
  assign RMS_OUT  = rms_out_q;

  isqrt_seq u_isqrt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .start_i    (sqrt_start),
    .radicand_i (radicand),
    .done_o     (sqrt_done),
    .root_o     (sqrt_root)
  );
`else
  logic unused_sum2;
  assign unused_sum2 = ^SUM2_IN;
  assign RMS_OUT     = '0;
`endif

  // Window counter: counts 0..2^LOG2_WIN while enabled; the flag is raised
  // for the cycle in which the count sits at 2^LOG2_WIN.
  always_comb begin
    wcnt_d      = wcnt_q;
    mean_flag_d = 1'b0;
    if (EN) begin
      wcnt_d      = (wcnt_q == WIN_LAST) ? '0 : wcnt_q + CNT_W'(1);
      mean_flag_d = (wcnt_q == WIN_PRE);
    end
  end

  always_comb begin
    state_d    = state_q;
    primed_d   = primed_q;
    mean_out_d = mean_out_q;
    pp_out_d   = pp_out_q;
`ifdef VOLTAGE_RMS_EN
    prev_sum2_d = prev_sum2_q;
    rms_out_d   = rms_out_q;
    mean_pend_d = mean_pend_q;
    pp_pend_d   = pp_pend_q;
    sqrt_start  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (mean_flag_q) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
`ifdef VOLTAGE_RMS_EN
        prev_sum2_d = SUM2_IN;
`endif
        if (!primed_q) begin
          // First window after reset only establishes the energy baseline.
          primed_d = 1'b1;
          state_d  = StIdle;
        end else begin
`ifdef VOLTAGE_RMS_EN
          mean_pend_d = mean_cap;
          pp_pend_d   = pp_cap;
          sqrt_start  = 1'b1;
          state_d     = StSqrt;
`else
          mean_out_d  = mean_cap;
          pp_out_d    = pp_cap;
          state_d     = StDone;
`endif
        end
      end
`ifdef VOLTAGE_RMS_EN
      StSqrt: begin
        if (sqrt_done) begin
          mean_out_d = mean_pend_q;
          pp_out_d   = pp_pend_q;
          rms_out_d  = sqrt_root;
          state_d    = StDone;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    rv_d   = (state_d == StDone);
    busy_d = (state_d != StIdle);
  end

  assign MEAN_FLAG    = mean_flag_q;
  assign MEAN_OUT     = mean_out_q;
  assign PP_OUT       = pp_out_q;
  assign RESULT_VALID = rv_q;
  assign BUSY         = busy_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt_q      <= '0;
      mean_flag_q <= 1'b0;
      state_q     <= StIdle;
      primed_q    <= 1'b0;
      mean_out_q  <= '0;
      pp_out_q    <= '0;
      rv_q        <= 1'b0;
      busy_q      <= 1'b0;
`ifdef VOLTAGE_RMS_EN
      prev_sum2_q <= '0;
      rms_out_q   <= '0;
      mean_pend_q <= '0;
      pp_pend_q   <= '0;
`endif
    end else begin
      wcnt_q      <= wcnt_d;
      mean_flag_q <= mean_flag_d;
      state_q     <= state_d;
      primed_q    <= primed_d;
      mean_out_q  <= mean_out_d;
      pp_out_q    <= pp_out_d;
      rv_q        <= rv_d;
      busy_q      <= busy_d;
`ifdef VOLTAGE_RMS_EN
      prev_sum2_q <= prev_sum2_d;
      rms_out_q   <= rms_out_d;
      mean_pend_q <= mean_pend_d;
      pp_pend_q   <= pp_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_voltage_stats_reader.sv
// Self-checking bench for voltage_stats_reader (LOG2_WIN = 8).
// Works with or without VOLTAGE_RMS_EN; latency and RMS expectations follow it.
module tb_voltage_stats_reader;

`ifdef VOLTAGE_RMS_EN
  localparam int LAT    = 14;
  localparam bit RMS_ON = 1'b1;
`else
  localparam int LAT    = 2;
  localparam bit RMS_ON = 1'b0;
`endif
  localparam int PERIOD = 257;
  localparam int NVEC   = 6;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic        MEAN_FLAG;
  logic [31:0] SUM_IN, SUM2_IN, MAX_IN, MIN_IN;
  logic [11:0] MEAN_OUT, RMS_OUT, PP_OUT;
  logic        RESULT_VALID;
  logic        BUSY;

  voltage_stats_reader #(.LOG2_WIN(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .EN           (EN),
    .MEAN_FLAG    (MEAN_FLAG),
    .SUM_IN       (SUM_IN),
    .SUM2_IN      (SUM2_IN),
    .MAX_IN       (MAX_IN),
    .MIN_IN       (MIN_IN),
    .MEAN_OUT     (MEAN_OUT),
    .RMS_OUT      (RMS_OUT),
    .PP_OUT       (PP_OUT),
    .RESULT_VALID (RESULT_VALID),
    .BUSY         (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] sum2;
    logic [31:0] max;
    logic [31:0] min;
    bit          res;
    int          mean;
    int          rms;
    int          pp;
  } vec_t;

  typedef struct {
    int mean;
    int rms;
    int pp;
  } exp_t;

  exp_t sb[$];
  int   n_chk     = 0;
  int   n_pass    = 0;
  int   last_flag = -1000;
  int   rv_cnt    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard consumer: every RESULT_VALID must match the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (MEAN_FLAG) last_flag = cyc;
    if (RESULT_VALID) begin
      rv_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_result_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("result_latency", cyc - last_flag, LAT);
        check("mean_out", int'(MEAN_OUT), e.mean);
        check("rms_out", int'(RMS_OUT), e.rms);
        check("pp_out", int'(PP_OUT), e.pp);
      end
    end
  end

  task automatic wait_flag(output int fcyc);
    fcyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if (MEAN_FLAG) begin
        fcyc = cyc;
        return;
      end
    end
    check("flag_timeout", 0, 1);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    SUM_IN  = v.sum;
    SUM2_IN = v.sum2;
    MAX_IN  = v.max;
    MIN_IN  = v.min;
    if (v.res) begin
      e.mean = v.mean;
      e.rms  = RMS_ON ? v.rms : 0;
      e.pp   = v.pp;
      sb.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mean"}, int'(MEAN_OUT), 0);
    check({tag, "_rms"}, int'(RMS_OUT), 0);
    check({tag, "_pp"}, int'(PP_OUT), 0);
    check({tag, "_valid"}, int'(RESULT_VALID), 0);
    check({tag, "_busy"}, int'(BUSY), 0);
  endtask

  vec_t vecs[NVEC];
  vec_t vr;
  int   f, prev_f, rv_snap;
  int   held_mean, held_rms, held_pp;
  bit   gap_pending;

  initial begin
    // sum, sum2, max, min, produces result, mean, rms, pp
    vecs[0] = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0, 0};                          // priming
    vecs[1] = '{32'd256000, 32'd256000000, 32'd1000, 32'd2048, 1'b1, 1000, 1000, 0}; // max < min
    vecs[2] = '{32'd256000, 32'd768000000, 32'd2000, 32'd0, 1'b1, 1000, 1414, 2000}; // square wave
    vecs[3] = '{32'h0012_3456, 32'hFFFF_0000, 32'd5000, 32'd100, 1'b1, 564, 3711, 4095};
    vecs[4] = '{32'd256000, 32'h0F41_4000, 32'd2048, 32'd1000, 1'b1, 1000, 1000, 1048}; // wrap
    vecs[5] = '{32'd512, 32'h0F41_4400, 32'd1234, 32'd1234, 1'b1, 2, 2, 0};

    RST = 1'b1;
    EN  = 1'b0;
    SUM_IN = '0; SUM2_IN = '0; MAX_IN = '0; MIN_IN = '0;
    repeat (3) @(negedge CLK);
    check("reset_flag", int'(MEAN_FLAG), 0);
    check_all_zero("reset");
    RST = 1'b0;
    EN  = 1'b1;

    prev_f = -1;
    gap_pending = 1'b0;
    held_mean = 0; held_rms = 0; held_pp = 0;
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i]);
      wait_flag(f);
      if (prev_f >= 0) check("flag_period", f - prev_f, gap_pending ? PERIOD + 50 : PERIOD);
      gap_pending = 1'b0;
      prev_f = f;
      @(negedge CLK);  // F+1
      check("flag_width", int'(MEAN_FLAG), 0);
      check("busy_at_capture", int'(BUSY), 1);
      check("hold_mean", int'(MEAN_OUT), held_mean);
      check("hold_rms", int'(RMS_OUT), held_rms);
      check("hold_pp", int'(PP_OUT), held_pp);
      if (i == 0) begin
        repeat (LAT + 4) @(negedge CLK);
        check("prime_no_result", rv_cnt, 0);
        check("prime_mean_zero", int'(MEAN_OUT), 0);
      end else if (i == 1) begin
        repeat (LAT - 1) @(negedge CLK);  // F+LAT
        check("busy_last", int'(BUSY), 1);
        check("valid_at_lat", int'(RESULT_VALID), 1);
        @(negedge CLK);
        check("busy_after", int'(BUSY), 0);
        check("valid_one_cycle", int'(RESULT_VALID), 0);
      end else if (i == 2) begin
        // Drop EN while the result is still being computed.
        repeat (3) @(negedge CLK);
        EN = 1'b0;
        repeat (50) @(negedge CLK);
        EN = 1'b1;
        gap_pending = 1'b1;
      end else begin
        repeat (LAT + 3) @(negedge CLK);
      end
      if (vecs[i].res) begin
        held_mean = vecs[i].mean;
        held_rms  = RMS_ON ? vecs[i].rms : 0;
        held_pp   = vecs[i].pp;
      end
    end
    repeat (LAT + 5) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);

    // Abort a computation with reset, then the priming sequence must repeat.
    vr = '{32'd256000, 32'h0AAA_0000, 32'd3000, 32'd10, 1'b0, 0, 0, 0};
    apply(vr);
    wait_flag(f);
    @(negedge CLK);
    if (RMS_ON) repeat (4) @(negedge CLK);
    check("busy_before_abort", int'(BUSY), 1);
    rv_snap = rv_cnt;
    RST = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge CLK);
    RST = 1'b0;

    vr = '{32'd256000, 32'h1234_0000, 32'd1000, 32'd2048, 1'b0, 0, 0, 0};
    apply(vr);
    wait_flag(f);
    repeat (LAT + 4) @(negedge CLK);
    check("reprime_no_result", rv_cnt, rv_snap);
    check("reprime_mean_zero", int'(MEAN_OUT), 0);

    vr = '{32'd256000, 32'h2176_4000, 32'd1000, 32'd2048, 1'b1, 1000, 1000, 0};
    apply(vr);
    wait_flag(f);
    repeat (LAT + 4) @(negedge CLK);
    check("post_reset_result_seen", rv_cnt, rv_snap + 1);
    check("scoreboard_drained_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
